// File: rtl/ipi_send_arbiter.sv
// Round-robin arbiter that shares the IPI mailbox sender CSR path between local requesters.
// Each grant issues SEND_MASK then TX_DATA, bounded by a bus timeout, and ends in a completion pulse.
module ipi_send_arbiter #(
    parameter int                REQS      = 4,
    parameter int                CORES     = 2,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0),
    parameter int                TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REQS-1:0]          req_valid,
    output logic [REQS-1:0]          req_ready,
    input  logic [REQS*CORES-1:0]    req_mask,
    input  logic [REQS*DATA_W-1:0]   req_data,
    output logic [REQS-1:0]          done_valid,
    output logic                     done_fault,
    output logic                     m_valid,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]        m_wdata,
    output logic [DATA_W/8-1:0]      m_wstrb,
    input  logic                     m_ready,
    input  logic                     m_fault,
    output logic                     busy,
    output logic [$clog2(REQS)-1:0]  grant_id
);

    localparam int GW     = $clog2(REQS);
    localparam int CW     = $clog2(TIMEOUT);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_MASK = 2'd1,
        ST_WR_DATA = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [CORES-1:0]    mask_q, mask_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                fault_q, fault_d;
    logic [CW-1:0]       tmo_q, tmo_d;

    logic                any_req_s;
    logic [GW-1:0]       gsel_s;
    logic [GW-1:0]       ptr_next_s;
    logic [CORES-1:0]    sel_mask_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                in_write_s;
    logic                stall_s;
    logic                tmo_hit_s;

    // Round-robin search from rr_ptr upward with wrap, plus payload mux for the winner
    always_comb begin
        logic [GW:0] sum_v;
        logic [GW:0] nxt_v;
        logic [GW-1:0] idx_v;
        any_req_s  = 1'b0;
        gsel_s     = {GW{1'b0}};
        sel_mask_s = {CORES{1'b0}};
        sel_data_s = {DATA_W{1'b0}};
        for (int k = 0; k < REQS; k++) begin
            sum_v     = {1'b0, rr_ptr_q} + (GW+1)'(k);
            sum_v     = (sum_v >= (GW+1)'(REQS)) ? (sum_v - (GW+1)'(REQS)) : sum_v;
            idx_v     = sum_v[GW-1:0];
            gsel_s    = (!any_req_s && req_valid[idx_v]) ? idx_v : gsel_s;
            any_req_s = any_req_s | req_valid[idx_v];
        end
        for (int i = 0; i < REQS; i++) begin
            sel_mask_s = (GW'(i) == gsel_s) ? req_mask[i*CORES +: CORES]  : sel_mask_s;
            sel_data_s = (GW'(i) == gsel_s) ? req_data[i*DATA_W +: DATA_W] : sel_data_s;
        end
        nxt_v      = {1'b0, gsel_s} + (GW+1)'(1);
        ptr_next_s = (nxt_v == (GW+1)'(REQS)) ? {GW{1'b0}} : nxt_v[GW-1:0];
    end

    assign in_write_s = (state_q == ST_WR_MASK) || (state_q == ST_WR_DATA);
    assign stall_s    = in_write_s && !m_ready;
    assign tmo_hit_s  = (tmo_q == CW'(TIMEOUT - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= {GW{1'b0}};
            grant_q  <= {GW{1'b0}};
            mask_q   <= {CORES{1'b0}};
            data_q   <= {DATA_W{1'b0}};
            fault_q  <= 1'b0;
            tmo_q    <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            fault_q  <= fault_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next-state logic; an m_ready on the timeout cycle takes priority over the timeout
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        mask_d   = mask_q;
        data_d   = data_q;
        fault_d  = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    grant_d  = gsel_s;
                    rr_ptr_d = ptr_next_s;
                    mask_d   = sel_mask_s;
                    data_d   = sel_data_s;
                    fault_d  = (sel_mask_s == {CORES{1'b0}});
                    state_d  = (sel_mask_s == {CORES{1'b0}}) ? ST_DONE : ST_WR_MASK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_MASK: begin
                if (m_ready) begin
                    fault_d = m_fault;
                    state_d = m_fault ? ST_DONE : ST_WR_DATA;
                end else if (tmo_hit_s) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WR_MASK;
                end
            end
            ST_WR_DATA: begin
                if (m_ready) begin
                    fault_d = m_fault;
                    state_d = ST_DONE;
                end else if (tmo_hit_s) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        tmo_d = (state_d != state_q) ? {CW{1'b0}} :
                (stall_s ? (tmo_q + CW'(1)) : tmo_q);
    end

    // Output decode; bus fields come only from registered state so they hold while stalled
    always_comb begin
        req_ready  = {REQS{1'b0}};
        done_valid = {REQS{1'b0}};
        done_fault = 1'b0;
        m_valid    = 1'b0;
        m_addr     = {ADDR_W{1'b0}};
        m_wdata    = {DATA_W{1'b0}};
        m_wstrb    = {STRB_W{1'b0}};
        busy       = (state_q != ST_IDLE);
        grant_id   = grant_q;
        case (state_q)
            ST_IDLE: begin
                for (int i = 0; i < REQS; i++) begin
                    req_ready[i] = rst_n && any_req_s && (GW'(i) == gsel_s);
                end
            end
            ST_WR_MASK: begin
                m_valid              = 1'b1;
                m_addr               = BASE_ADDR;
                m_wdata[CORES-1:0]   = mask_q;
                m_wstrb              = {STRB_W{1'b1}};
            end
            ST_WR_DATA: begin
                m_valid = 1'b1;
                m_addr  = BASE_ADDR + ADDR_W'(32'd4);
                m_wdata = data_q;
                m_wstrb = {STRB_W{1'b1}};
            end
            ST_DONE: begin
                for (int i = 0; i < REQS; i++) begin
                    done_valid[i] = (GW'(i) == grant_q);
                end
                done_fault = fault_q;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/ipi_send_arbiter.md
Name: ipi_send_arbiter

Overview:
- Shares the single sender-side CSR write path of the IPI mailbox between REQS local requesters (e.g. cores, DMA, debug).
- Each request is one message: destination mask plus payload. The block arbitrates round-robin and sequences the two mailbox writes in order: SEND_MASK at BASE_ADDR+0x0, then TX_DATA at BASE_ADDR+0x4.
- It reports per-requester completion and fault, and enforces a bus timeout.

Parameters:
- REQS, 4, number of requesters (2..8)
- CORES, 2, width of destination mask
- DATA_W, 32, message payload and CSR data width
- ADDR_W, 32, CSR address width
- BASE_ADDR, 32'h0, mailbox register base
- TIMEOUT, 16, max cycles m_valid may wait for m_ready (>=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  REQS  request pending per requester, held until accepted
- req_ready  out  REQS  one-hot one-cycle accept pulse
- req_mask  in  REQS*CORES  destination mask, slice i for requester i
- req_data  in  REQS*DATA_W  payload, slice i
- done_valid  out  REQS  one-hot one-cycle completion pulse
- done_fault  out  1  qualifies done_valid: 1 = message not delivered
- m_valid  out  1  CSR write request
- m_addr  out  ADDR_W  CSR address
- m_wdata  out  DATA_W  CSR write data
- m_wstrb  out  DATA_W/8  byte strobes, all ones when m_valid
- m_ready  in  1  write accepted this cycle
- m_fault  in  1  valid with m_ready: write faulted
- busy  out  1  FSM not IDLE
- grant_id  out  $clog2(REQS)  index of current or last granted requester

Behaviour:
- Reset (rst_n low at a clk edge): FSM=IDLE; rr_ptr=0; all outputs 0 (req_ready, done_valid, done_fault, m_valid, m_addr, m_wdata, m_wstrb, busy, grant_id); timeout counter 0.
- Reset mid-transfer aborts without a done pulse. Any in-flight m_valid drops the cycle after the reset edge.
- States: IDLE, WR_MASK, WR_DATA, DONE.
- IDLE:
  - If any req_valid, select the first set bit searching from rr_ptr upward with wrap.
  - Same cycle: combinational req_ready[g]=1.
  - Next edge: latch mask/data, set grant_id=g, set rr_ptr=(g+1) mod REQS.
  - If the latched mask is 0, go to DONE with fault=1 and issue no bus write. Otherwise go to WR_MASK.
  - Otherwise stay in IDLE.
- WR_MASK:
  - m_valid=1, m_addr=BASE_ADDR, m_wdata=zero-extended mask.
  - On m_ready: if m_fault, go to DONE with fault=1 (TX_DATA is skipped). Else go to WR_DATA.
- WR_DATA:
  - m_valid=1, m_addr=BASE_ADDR+4, m_wdata=data.
  - On m_ready, go to DONE with fault=m_fault.
- Timeout:
  - Counter clears on state entry and increments each cycle m_valid=1 && !m_ready.
  - When the count reaches TIMEOUT-1 without m_ready, the next edge goes to DONE with fault=1 and m_valid drops.
  - An m_ready arriving on that same cycle wins, and the write is treated as normal.
- DONE:
  - done_valid[grant_id]=1 and done_fault=fault for exactly one cycle, then IDLE.
  - No new grant is made in DONE. Back-to-back minimum spacing is one IDLE cycle.
- Latency: accept at cycle N; m_valid from N+1. With m_ready tied high: mask write N+1, data write N+2, done N+3, next accept N+4.
- m_addr, m_wdata and m_wstrb are stable while m_valid is high and unaccepted.
- req_valid deasserting before grant is legal. Inputs are ignored outside IDLE.
- Simultaneous requests are served in round-robin order. A single persistent requester is granted each round. No requester waits more than REQS-1 other grants.

Test Plan:
- Reset, then req_valid[1]=1, mask=2'b10, data=32'hDEAD_BEEF, m_ready=1 -> req_ready[1] pulse at N; writes (0x0,0x2) at N+1 and (0x4,0xDEADBEEF) at N+2; done_valid[1] at N+3 with done_fault=0.
- req_valid=4'b1111 held, m_ready=1 -> grants 0,1,2,3,0; consecutive req_ready pulses exactly 4 cycles apart.
- m_ready held low for 3 cycles per write -> m_valid/m_addr/m_wdata stable while stalled; done at accept+1 with fault=0.
- m_fault=1 on the mask write -> no write to 0x4; done_valid pulse with done_fault=1.
- m_ready held low, TIMEOUT=16 -> m_valid drops after 16 cycles; done_fault=1. Mask=0 request -> no m_valid; done_fault=1 one cycle after the grant cycle.
- rst_n low during WR_DATA -> m_valid=0, busy=0, no done pulse; a subsequent request is granted starting from requester 0.
